// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts an N-bit word over valid/ready
// and shifts it out one bit per clock, qualified by so_valid and so_last.
module piso_shift_tx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] pi,
  output logic         so,
  output logic         so_valid,
  output logic         so_last,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          end_of_word;
  logic          take;

  assign end_of_word = (state == SHIFT) && (cnt == LAST);
  assign load_ready  = (state == IDLE) || end_of_word;
  assign take        = load_valid && load_ready;
  assign busy        = (state == SHIFT);
  assign cnt_nxt     = cnt + 1'b1;

  // The first bit goes straight to so at the handshake edge; sreg keeps the
  // remaining bits aligned so the next one is always at the outgoing end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_last  <= 1'b0;
    end else if (take) begin
      state    <= SHIFT;
      cnt      <= '0;
      so_valid <= 1'b1;
      so_last  <= 1'b0;
      if (MSB_FIRST) begin
        so   <= pi[N-1];
        sreg <= {pi[N-2:0], 1'b0};
      end else begin
        so   <= pi[0];
        sreg <= {1'b0, pi[N-1:1]};
      end
    end else if (end_of_word || state == IDLE) begin
      state    <= IDLE;
      cnt      <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_last  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      so_valid <= 1'b1;
      so_last  <= (cnt_nxt == LAST);
      if (MSB_FIRST) begin
        so   <= sreg[N-1];
        sreg <= {sreg[N-2:0], 1'b0};
      end else begin
        so   <= sreg[0];
        sreg <= {1'b0, sreg[N-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: an MSB-first and an LSB-first instance.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lv_m = 1'b0, lv_l = 1'b0;
  logic [7:0] pi_m = '0, pi_l = '0;
  logic       rdy_m, so_m, sov_m, sol_m, busy_m;
  logic       rdy_l, so_l, sov_l, sol_l, busy_l;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_valid(lv_m), .load_ready(rdy_m), .pi(pi_m),
    .so(so_m), .so_valid(sov_m), .so_last(sol_m), .busy(busy_m));

  piso_shift_tx #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_valid(lv_l), .load_ready(rdy_l), .pi(pi_l),
    .so(so_l), .so_valid(sov_l), .so_last(sol_l), .busy(busy_l));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({so_m, sov_m, sol_m, busy_m, rdy_m} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_msb: got so/vld/last/busy/rdy=%b want 00001", {so_m, sov_m, sol_m, busy_m, rdy_m});
    end
    checks++;
    if ({so_l, sov_l, sol_l, busy_l, rdy_l} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_lsb: got so/vld/last/busy/rdy=%b want 00001", {so_l, sov_l, sol_l, busy_l, rdy_l});
    end
  endtask

  task automatic test_msb_first(input logic [7:0] w);
    @(posedge clk); #1 lv_m = 1'b1; pi_m = w;
    @(posedge clk); #1 lv_m = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({so_m, sov_m, sol_m, busy_m, rdy_m} !== {w[7-k], 1'b1, k == 7, 1'b1, k == 7}) begin
        errors++;
        $display("FAIL msb_bit%0d w=%h: got so/vld/last/busy/rdy=%b want %b", k, w,
                 {so_m, sov_m, sol_m, busy_m, rdy_m}, {w[7-k], 1'b1, k == 7, 1'b1, k == 7});
      end
    end
    @(negedge clk);
    checks++;
    if ({so_m, sov_m, sol_m, busy_m} !== 4'b0000) begin
      errors++;
      $display("FAIL msb_idle w=%h: got so/vld/last/busy=%b want 0000", w, {so_m, sov_m, sol_m, busy_m});
    end
  endtask

  task automatic test_lsb_first(input logic [7:0] w);
    @(posedge clk); #1 lv_l = 1'b1; pi_l = w;
    @(posedge clk); #1 lv_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({so_l, sov_l, sol_l} !== {w[k], 1'b1, k == 7}) begin
        errors++;
        $display("FAIL lsb_bit%0d w=%h: got so/vld/last=%b want %b", k, w,
                 {so_l, sov_l, sol_l}, {w[k], 1'b1, k == 7});
      end
    end
    @(negedge clk);
    checks++;
    if ({so_l, sov_l, busy_l} !== 3'b000) begin
      errors++;
      $display("FAIL lsb_idle w=%h: got so/vld/busy=%b want 000", w, {so_l, sov_l, busy_l});
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 lv_m = 1'b1; pi_m = 8'hFF;
    @(posedge clk); #1 pi_m = 8'h00;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({so_m, sov_m, sol_m} !== {k < 8, 1'b1, (k == 7) || (k == 15)}) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got so/vld/last=%b want %b", k + 1,
                 {so_m, sov_m, sol_m}, {k < 8, 1'b1, (k == 7) || (k == 15)});
      end
      if (k == 7) begin
        @(posedge clk); #1 lv_m = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({sov_m, busy_m} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: got vld/busy=%b want 00", {sov_m, busy_m});
    end
  endtask

  task automatic test_ignore();
    logic [7:0] w = 8'h96;
    @(posedge clk); #1 lv_m = 1'b1; pi_m = w;
    @(posedge clk); #1 lv_m = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({so_m, sov_m, sol_m} !== {w[7-k], 1'b1, k == 7}) begin
        errors++;
        $display("FAIL ignore_bit%0d: got so/vld/last=%b want %b", k,
                 {so_m, sov_m, sol_m}, {w[7-k], 1'b1, k == 7});
      end
      if (k == 2) begin lv_m = 1'b1; pi_m = 8'h3C; end
      if (k == 4) lv_m = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({so_m, sov_m, busy_m} !== 3'b000) begin
        errors++;
        $display("FAIL ignore_idle: got so/vld/busy=%b want 000", {so_m, sov_m, busy_m});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 lv_m = 1'b1; pi_m = 8'hF0;
    @(posedge clk); #1 lv_m = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({so_m, sov_m} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_bit3: got so/vld=%b want 11", {so_m, sov_m});
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({so_m, sov_m, sol_m, busy_m, rdy_m} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_after: got so/vld/last/busy/rdy=%b want 00001", {so_m, sov_m, sol_m, busy_m, rdy_m});
    end
    test_msb_first(8'h81);
  endtask

  task automatic test_reset_load();
    @(posedge clk); #1 reset = 1'b1; lv_m = 1'b1; pi_m = 8'hFF;
    @(posedge clk); #1 reset = 1'b0; lv_m = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({so_m, sov_m, busy_m} !== 3'b000) begin
        errors++;
        $display("FAIL rst_and_load: got so/vld/busy=%b want 000", {so_m, sov_m, busy_m});
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first(8'hA5);
    test_lsb_first(8'hA5);
    test_lsb_first(8'h01);
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_reset_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
